// File: rtl/trng_pkg.sv
// Shared constants and read-FSM encoding for the TRNG word consumer.
package trng_pkg;

  localparam int TRNG_WORD_W = 32;
  localparam int OVF_CNT_W   = 16;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_POP  = 2'd1,
    RD_ACK  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/trng_sync_fifo.sv
// Single-clock FIFO with extended pointers; flush clears both pointers and
// discards any push in the same cycle, while a pop in that cycle still reads the head.
module trng_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              push_ok;
  logic              pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // A pop frees the slot being written when full, so the write may land there.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && !flush && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/trng_word_reader.sv
// TRNG word consumer: buffers words in a FIFO, runs a repetition-count health
// test, counts overflow drops and serves words over a four-phase req/ack read.
module trng_word_reader
  import trng_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int RCT_CUTOFF = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TRNG_WORD_W-1:0] word_in,
  input  logic                   word_valid,
  input  logic                   rd_req,
  output logic [TRNG_WORD_W-1:0] rd_data,
  output logic                   rd_ack,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [ADDR_W:0]        fill_level,
  output logic                   overflow,
  output logic [OVF_CNT_W-1:0]   overflow_count,
  output logic                   health_fail,
  input  logic                   clr_status,
  input  logic                   flush,
  output logic [1:0]             dbg_state
);

  localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
  localparam logic [RCT_W-1:0]     RCT_LIM = RCT_W'(RCT_CUTOFF);
  localparam logic [RCT_W-1:0]     REP_ONE = {{(RCT_W-1){1'b0}}, 1'b1};
  localparam logic [OVF_CNT_W-1:0] CNT_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

  rd_state_e state_q, state_d;
  logic [TRNG_WORD_W-1:0] rd_data_q, rd_data_d;
  logic                   rd_ack_q, rd_ack_d;
  logic                   ovf_q, ovf_d;
  logic [OVF_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   hf_q, hf_d;
  logic [RCT_W-1:0]       rep_q, rep_d, rep_next;
  logic [TRNG_WORD_W-1:0] last_q, last_d;
  logic                   last_vld_q, last_vld_d;

  logic [TRNG_WORD_W-1:0] head;
  logic pop, room, eligible, drop;

  // Handshake: rd_req rises -> POP (head latched) -> ACK with rd_ack=1 and
  // rd_data held; rd_req falling returns to IDLE and drops rd_ack on that edge.
  assign pop      = (state_q == RD_POP);
  assign room     = !fifo_full || pop;
  assign eligible = word_valid && !hf_q && !flush && room;
  assign drop     = word_valid && !hf_q && !flush && !room;
  assign rep_next = (last_vld_q && (word_in == last_q)) ? rep_q + REP_ONE : REP_ONE;

  trng_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (TRNG_WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (eligible),
    .pop   (pop),
    .flush (flush),
    .wdata (word_in),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fill_level)
  );

  always_comb begin
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    hf_d       = hf_q;
    rep_d      = rep_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    // Clear beats a same-cycle drop so the count ends at zero.
    if (clr_status) begin
      ovf_d      = 1'b0;
      cnt_d      = '0;
      hf_d       = 1'b0;
      rep_d      = '0;
      last_vld_d = 1'b0;
    end else begin
      if (eligible) begin
        rep_d      = rep_next;
        last_d     = word_in;
        last_vld_d = 1'b1;
        if (rep_next >= RCT_LIM) hf_d = 1'b1;
      end
      if (drop) begin
        ovf_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    rd_ack_d  = rd_ack_q;
    case (state_q)
      RD_IDLE: if (rd_req && !fifo_empty && !flush) state_d = RD_POP;
      RD_POP: begin
        rd_data_d = head;
        rd_ack_d  = 1'b1;
        state_d   = RD_ACK;
      end
      RD_ACK: begin
        if (!rd_req) begin
          rd_ack_d = 1'b0;
          state_d  = RD_IDLE;
        end
      end
      default: begin
        rd_ack_d = 1'b0;
        state_d  = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      rd_data_q  <= '0;
      rd_ack_q   <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      hf_q       <= 1'b0;
      rep_q      <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_ack_q   <= rd_ack_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      hf_q       <= hf_d;
      rep_q      <= rep_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign rd_data        = rd_data_q;
  assign rd_ack         = rd_ack_q;
  assign overflow       = ovf_q;
  assign overflow_count = cnt_q;
  assign health_fail    = hf_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_trng_word_reader.sv
// Randomized scoreboard bench for trng_word_reader against a queue-based model.
module tb_trng_word_reader;

  localparam int DEPTH = 8;
  localparam int ADDR_W = 3;
  localparam int RCT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        fifo_empty, fifo_full;
  logic [ADDR_W:0] fill_level;
  logic        overflow;
  logic [15:0] overflow_count;
  logic        health_fail;
  logic        clr_status = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  dbg_state;

  trng_word_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RCT_CUTOFF(RCT)) dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fill_level(fill_level),
    .overflow(overflow), .overflow_count(overflow_count),
    .health_fail(health_fail), .clr_status(clr_status), .flush(flush),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] m_q[$];
  logic [31:0] exp_q[$];
  bit          m_ovf, m_hf, m_have_last;
  logic [15:0] m_cnt;
  int          m_rep;
  logic [31:0] m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    exp_q.delete();
    m_ovf = 0; m_hf = 0; m_have_last = 0; m_cnt = 0; m_rep = 0; m_last = 0;
  endfunction

  function automatic void m_clear_status();
    m_ovf = 0; m_hf = 0; m_have_last = 0; m_cnt = 0; m_rep = 0;
  endfunction

  function automatic void m_write(input logic [31:0] w);
    if (m_hf) return;
    if (m_q.size() == DEPTH) begin
      m_ovf = 1;
      if (m_cnt != 16'hFFFF) m_cnt++;
      return;
    end
    if (m_have_last && w == m_last) m_rep++;
    else m_rep = 1;
    m_last = w;
    m_have_last = 1;
    m_q.push_back(w);
    if (m_rep >= RCT) m_hf = 1;
  endfunction

  // monitor: pops the expected word whenever rd_ack rises, checks it is held
  logic        ack_prev = 1'b0;
  logic [31:0] exp_cur = '0;
  always @(negedge clk) begin
    if (rst_n && rd_ack && !ack_prev) begin
      if (exp_q.size() == 0) chk("rd_unexpected_ack", 32'd1, 32'd0);
      else begin
        exp_cur = exp_q.pop_front();
        chk("rd_data", rd_data, exp_cur);
      end
    end else if (rst_n && rd_ack && ack_prev) begin
      chk("rd_data_hold", rd_data, exp_cur);
    end
    ack_prev = rd_ack;
  end

  // drivers
  task automatic do_reset();
    rst_n = 1'b0; word_valid = 0; rd_req = 0; clr_status = 0; flush = 0;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_word(input logic [31:0] w);
    @(negedge clk);
    word_in = w; word_valid = 1'b1;
    m_write(w);
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic read_word();
    int cyc;
    @(negedge clk);
    rd_req = 1'b1;
    if (m_q.size() > 0) exp_q.push_back(m_q.pop_front());
    cyc = 0;
    while (!rd_ack && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rd_latency", cyc, 2);
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_fall", rd_ack, 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_status = 1'b1;
    m_clear_status();
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    m_q.delete();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ":fifo_empty"}, fifo_empty, m_q.size() == 0);
    chk({tag, ":fifo_full"}, fifo_full, m_q.size() == DEPTH);
    chk({tag, ":fill_level"}, fill_level, m_q.size());
    chk({tag, ":overflow"}, overflow, m_ovf);
    chk({tag, ":overflow_count"}, overflow_count, m_cnt);
    chk({tag, ":health_fail"}, health_fail, m_hf);
  endtask

  initial begin
    int cyc;
    logic [31:0] w, last_w;

    // reset state
    do_reset();
    chk("reset:rd_data", rd_data, 0);
    chk("reset:rd_ack", rd_ack, 0);
    chk("reset:state", dbg_state, 0);
    check_status("reset");

    // basic ordering
    write_word(32'h11111111);
    write_word(32'h22222222);
    write_word(32'h33333333);
    check_status("three_writes");
    repeat (3) read_word();
    check_status("three_reads");

    // overflow: 10 distinct words into 8 entries
    do_reset();
    for (int i = 1; i <= 10; i++) write_word(32'hA000_0000 + i);
    check_status("overflow");
    chk("overflow:count_is_2", overflow_count, 2);

    // write in the POP cycle while full
    @(negedge clk);
    rd_req = 1'b1;
    exp_q.push_back(m_q.pop_front());
    cyc = 0;
    while (dbg_state != 2'd1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("pop_cycle_reached", dbg_state, 1);
    word_in = 32'hB0B0_0001; word_valid = 1'b1;
    m_write(32'hB0B0_0001);
    @(negedge clk);
    word_valid = 1'b0;
    chk("pop_write:rd_ack", rd_ack, 1);
    rd_req = 1'b0;
    @(negedge clk);
    check_status("pop_write");
    chk("pop_write:level_8", fill_level, 8);
    repeat (8) read_word();
    check_status("drain");

    // repetition-count health test
    do_reset();
    repeat (3) write_word(32'hDEADBEEF);
    check_status("rct_trip");
    chk("rct_trip:hf", health_fail, 1);
    write_word(32'h12345678);
    check_status("rct_blocked");
    pulse_clr();
    check_status("rct_clr");
    write_word(32'hCAFEF00D);
    check_status("rct_resume");
    repeat (4) read_word();

    // request on empty FIFO, then flush during ACK
    do_reset();
    @(negedge clk);
    rd_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("empty_wait:rd_ack", rd_ack, 0);
    chk("empty_wait:state", dbg_state, 0);
    word_in = 32'h5A5A_A5A5; word_valid = 1'b1;
    m_write(32'h5A5A_A5A5);
    exp_q.push_back(m_q.pop_front());
    cyc = 0;
    do begin
      @(negedge clk);
      word_valid = 1'b0;
      cyc++;
    end while (!rd_ack && cyc < 20);
    chk("empty_wait:latency", cyc, 3);
    write_word(32'h0000_0001);
    write_word(32'h0000_0002);
    check_status("ack_two_queued");
    pulse_flush();
    check_status("ack_flush");
    chk("ack_flush:rd_ack", rd_ack, 1);
    chk("ack_flush:rd_data", rd_data, 32'h5A5A_A5A5);
    rd_req = 1'b0;
    @(negedge clk);
    chk("ack_flush:release", rd_ack, 0);

    // asynchronous reset mid-handshake
    for (int i = 0; i < 9; i++) write_word(32'hC000_0000 + i);
    check_status("pre_reset");
    @(negedge clk);
    rd_req = 1'b1;
    exp_q.push_back(m_q.pop_front());
    cyc = 0;
    while (!rd_ack && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("pre_reset:rd_ack", rd_ack, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset:rd_ack", rd_ack, 0);
    chk("async_reset:fill_level", fill_level, 0);
    chk("async_reset:overflow_count", overflow_count, 0);
    chk("async_reset:health_fail", health_fail, 0);
    chk("async_reset:state", dbg_state, 0);
    rd_req = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    write_word(32'h7777_0000);
    read_word();
    check_status("post_reset");

    // randomized mix
    last_w = 32'h0;
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4 || (r <= 7 && m_q.size() == 0)) begin
        w = ($urandom_range(0, 3) == 0) ? last_w : $urandom;
        last_w = w;
        write_word(w);
      end else if (r <= 7) begin
        read_word();
      end else if (r == 8) begin
        pulse_clr();
      end else if ($urandom_range(0, 3) == 0) begin
        pulse_flush();
      end else begin
        w = $urandom;
        last_w = w;
        write_word(w);
      end
      check_status("random");
    end

    while (m_q.size() > 0) read_word();
    check_status("final_drain");
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
